// File: rtl/sd_emmc_controller_dma_rd.sv
// ---------------------------------------------------------------------------
// sd_emmc_controller_dma_rd
//
// SDMA read engine for the card-write direction (system memory -> card).
// It fetches 512-byte blocks from system memory one 32-bit word at a time.
// Each fetch is a single-beat AXI read, and only one read is outstanding at
// any moment. Every returned word is pushed into the TX FIFO that feeds the
// serial data path.
//
// At every buffer boundary (8 << buf_boundary blocks) the engine pauses. It
// resumes when the host rewrites the SDMA system address. The transfer ends
// after block_count blocks when blk_count_ena is set. Any AXI error response
// stops the engine in ERROR.
//
// Ports
//   clock, reset           : clock; asynchronous active-low reset
//   init_dma_sys_addr      : SDMA system address (start / reload value)
//   buf_boundary           : boundary code, blocks per boundary = 8 << code
//   block_count            : blocks to move; blk_count_ena enables the limit
//   dma_ena_trans_mode     : DMA enable from Transfer Mode
//   dir_dat_trans_mode     : 0 selects this engine (write to card)
//   start_xfer, stop_xfer  : start pulse / abort level
//   sys_addr_changed       : pulse when the host rewrites the SDMA address
//   fifo_full, fifo_wr_en,
//   fifo_wr_data           : TX FIFO push side
//   read_addr, addr_read_valid, addr_read_ready,
//   read_data, read_resp, read_data_valid,
//   read_data_ready        : AXI AR / R channels
//   dma_boundary_int, dma_done,
//   dma_error              : one-cycle event pulses to the register block
//   busy                   : high whenever the engine is not idle
// ---------------------------------------------------------------------------
module sd_emmc_controller_dma_rd #(
    parameter int ADDR_W    = 32,
    parameter int BLKCNT_W  = 16,
    parameter int BLK_WORDS = 128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   init_dma_sys_addr,
    input  logic [2:0]          buf_boundary,
    input  logic [BLKCNT_W-1:0] block_count,
    input  logic                blk_count_ena,
    input  logic                dma_ena_trans_mode,
    input  logic                dir_dat_trans_mode,
    input  logic                start_xfer,
    input  logic                stop_xfer,
    input  logic                sys_addr_changed,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [31:0]         fifo_wr_data,
    output logic [ADDR_W-1:0]   read_addr,
    output logic                addr_read_valid,
    input  logic                addr_read_ready,
    input  logic [31:0]         read_data,
    input  logic [1:0]          read_resp,
    input  logic                read_data_valid,
    output logic                read_data_ready,
    output logic                dma_boundary_int,
    output logic                dma_done,
    output logic                dma_error,
    output logic                busy
);

    localparam int WORD_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    // Largest boundary is 8 << 7 = 1024 blocks, which needs 11 bits.
    localparam int BND_W  = 11;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WAIT_SPACE   = 3'd1;
    localparam logic [2:0] S_ADDR         = 3'd2;
    localparam logic [2:0] S_DATA         = 3'd3;
    localparam logic [2:0] S_BLK_CHECK    = 3'd4;
    localparam logic [2:0] S_NEW_SYS_ADDR = 3'd5;
    localparam logic [2:0] S_DONE         = 3'd6;
    localparam logic [2:0] S_ERROR        = 3'd7;

    logic [2:0]          state;
    logic [WORD_W-1:0]   word_cnt;
    logic [BLKCNT_W-1:0] blocks_total;
    logic [BND_W-1:0]    blocks_in_bnd;
    logic [BND_W-1:0]    bound;

    logic                start_ok;
    logic                last_word;
    logic [BLKCNT_W-1:0] blk_target;
    logic                xfer_complete;
    logic                at_boundary;
    logic                rd_handshake;

    assign start_ok     = start_xfer & dma_ena_trans_mode & ~dir_dat_trans_mode;
    assign last_word    = (word_cnt == WORD_W'(BLK_WORDS - 1));
    assign rd_handshake = read_data_valid & read_data_ready;

    // A block count of 0 follows the register rule for that value and moves
    // exactly one block.
    assign blk_target    = (block_count == '0) ? BLKCNT_W'(1) : block_count;
    assign xfer_complete = blk_count_ena & (blocks_total == blk_target);
    assign at_boundary   = (blocks_in_bnd == bound);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            word_cnt         <= '0;
            blocks_total     <= '0;
            blocks_in_bnd    <= '0;
            bound            <= '0;
            read_addr        <= '0;
            addr_read_valid  <= 1'b0;
            read_data_ready  <= 1'b0;
            fifo_wr_en       <= 1'b0;
            fifo_wr_data     <= '0;
            dma_boundary_int <= 1'b0;
            dma_done         <= 1'b0;
            dma_error        <= 1'b0;
        end else begin
            // Strobes and event outputs are single-cycle pulses.
            fifo_wr_en       <= 1'b0;
            dma_boundary_int <= 1'b0;
            dma_done         <= 1'b0;
            dma_error        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        read_addr     <= init_dma_sys_addr;
                        word_cnt      <= '0;
                        blocks_total  <= '0;
                        blocks_in_bnd <= '0;
                        // Latch the boundary size once per transfer.
                        bound         <= BND_W'(11'd8 << buf_boundary);
                        state         <= S_WAIT_SPACE;
                    end
                end

                S_WAIT_SPACE: begin
                    if (stop_xfer && word_cnt == '0) begin
                        state <= S_IDLE;
                    end else if (!fifo_full) begin
                        addr_read_valid <= 1'b1;
                        state           <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    // ARADDR/ARVALID stay stable until the slave accepts them.
                    if (addr_read_ready) begin
                        addr_read_valid <= 1'b0;
                        read_data_ready <= 1'b1;
                        state           <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (rd_handshake) begin
                        read_data_ready <= 1'b0;
                        if (read_resp != 2'b00) begin
                            dma_error <= 1'b1;
                            state     <= S_ERROR;
                        end else begin
                            fifo_wr_en   <= 1'b1;
                            fifo_wr_data <= read_data;
                            read_addr    <= read_addr + ADDR_W'(4);
                            if (last_word) begin
                                word_cnt      <= '0;
                                blocks_total  <= blocks_total + BLKCNT_W'(1);
                                blocks_in_bnd <= blocks_in_bnd + BND_W'(1);
                                state         <= S_BLK_CHECK;
                            end else begin
                                word_cnt <= word_cnt + WORD_W'(1);
                                state    <= S_WAIT_SPACE;
                            end
                        end
                    end
                end

                S_BLK_CHECK: begin
                    // Completion wins over both a pending stop and a boundary.
                    if (xfer_complete) begin
                        dma_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (stop_xfer) begin
                        state <= S_IDLE;
                    end else if (at_boundary) begin
                        dma_boundary_int <= 1'b1;
                        state            <= S_NEW_SYS_ADDR;
                    end else begin
                        state <= S_WAIT_SPACE;
                    end
                end

                S_NEW_SYS_ADDR: begin
                    if (sys_addr_changed) begin
                        read_addr     <= init_dma_sys_addr;
                        blocks_in_bnd <= '0;
                        state         <= S_WAIT_SPACE;
                    end else if (stop_xfer) begin
                        state <= S_IDLE;
                    end
                end

                S_DONE: begin
                    // Wait until the start pulse has gone away so that a
                    // lingering start cannot immediately relaunch the engine.
                    if (!start_xfer) begin
                        state <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    if (!dma_ena_trans_mode || stop_xfer) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_emmc_controller_dma_rd.sv
module tb_sd_emmc_controller_dma_rd;

    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] init_dma_sys_addr = '0;
    logic [2:0]  buf_boundary = '0;
    logic [15:0] block_count = '0;
    logic        blk_count_ena = 1'b1;
    logic        dma_ena_trans_mode = 1'b1;
    logic        dir_dat_trans_mode = 1'b0;
    logic        start_xfer = 1'b0;
    logic        stop_xfer = 1'b0;
    logic        sys_addr_changed = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [31:0] read_addr;
    logic        addr_read_valid;
    logic        addr_read_ready = 1'b0;
    logic [31:0] read_data = '0;
    logic [1:0]  read_resp = '0;
    logic        read_data_valid = 1'b0;
    logic        read_data_ready;
    logic        dma_boundary_int;
    logic        dma_done;
    logic        dma_error;
    logic        busy;

    sd_emmc_controller_dma_rd dut (
        .clock              (clock),
        .reset              (reset),
        .init_dma_sys_addr  (init_dma_sys_addr),
        .buf_boundary       (buf_boundary),
        .block_count        (block_count),
        .blk_count_ena      (blk_count_ena),
        .dma_ena_trans_mode (dma_ena_trans_mode),
        .dir_dat_trans_mode (dir_dat_trans_mode),
        .start_xfer         (start_xfer),
        .stop_xfer          (stop_xfer),
        .sys_addr_changed   (sys_addr_changed),
        .fifo_full          (fifo_full),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_wr_data       (fifo_wr_data),
        .read_addr          (read_addr),
        .addr_read_valid    (addr_read_valid),
        .addr_read_ready    (addr_read_ready),
        .read_data          (read_data),
        .read_resp          (read_resp),
        .read_data_valid    (read_data_valid),
        .read_data_ready    (read_data_ready),
        .dma_boundary_int   (dma_boundary_int),
        .dma_done           (dma_done),
        .dma_error          (dma_error),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // AXI slave model: memory word at address A reads back as A ^ KEY.
    int          ar_delay = 0;
    int          r_delay  = 0;
    int          err_word = -1;
    int          ar_wait  = 0;
    int          r_wait   = 0;
    int          r_idx    = 0;
    int          ar_hs    = 0;
    int          addr_unstable = 0;
    bit          pending  = 0;
    logic [31:0] ar_first = '0;
    logic [31:0] lat_addr = '0;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            addr_read_ready = 1'b0;
            read_data_valid = 1'b0;
            read_resp       = 2'b00;
            pending = 0;
            ar_wait = 0;
            r_wait  = 0;
        end else begin
            if (addr_read_ready) begin
                // Ready was high over the last edge with valid held: accepted.
                addr_read_ready = 1'b0;
                ar_wait = 0;
                pending = 1;
                r_wait  = 0;
                ar_hs++;
            end else if (addr_read_valid) begin
                if (ar_wait == 0) ar_first = read_addr;
                else if (read_addr !== ar_first) addr_unstable++;
                if (ar_wait >= ar_delay) begin
                    addr_read_ready = 1'b1;
                    lat_addr = read_addr;
                end else begin
                    ar_wait++;
                end
            end
            if (read_data_valid) begin
                read_data_valid = 1'b0;
                read_resp = 2'b00;
                r_idx++;
            end else if (pending) begin
                if (r_wait >= r_delay) begin
                    read_data_valid = 1'b1;
                    read_data = lat_addr ^ KEY;
                    read_resp = (r_idx == err_word) ? 2'b10 : 2'b00;
                    pending = 0;
                end else begin
                    r_wait++;
                end
            end
        end
    end

    // FIFO / event monitor; also drives fifo_full for the stall scenario.
    logic [31:0] wr_q[$];
    int done_cnt = 0;
    int bnd_cnt  = 0;
    int err_cnt  = 0;
    int stall_after = -1;
    int stall_left  = 0;
    int ar_during_full = 0;
    int ar_after_stall = 0;
    bit chk_ar_next = 0;

    always @(negedge clock) begin
        if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
        if (dma_done) done_cnt++;
        if (dma_boundary_int) bnd_cnt++;
        if (dma_error) err_cnt++;
        if (fifo_full && addr_read_valid) ar_during_full++;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) begin
                fifo_full = 1'b0;
                chk_ar_next = 1;
            end
        end else if (chk_ar_next) begin
            ar_after_stall = addr_read_valid ? 1 : 0;
            chk_ar_next = 0;
        end
        if (fifo_wr_en && wr_q.size() == stall_after) begin
            fifo_full = 1'b1;
            stall_left = 50;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input int first, input int n, input logic [31:0] base, input string tag);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] expv;
            expv = (base + 32'(4 * i)) ^ KEY;
            if (first + i >= wr_q.size() || wr_q[first + i] !== expv) errs++;
        end
        chk(tag, 64'(errs), 64'd0);
    endtask

    task automatic launch(input logic [31:0] a, input logic [2:0] bb, input logic [15:0] bc, input logic ena);
        wr_q.delete();
        done_cnt = 0; bnd_cnt = 0; err_cnt = 0;
        ar_hs = 0; r_idx = 0; addr_unstable = 0;
        ar_during_full = 0; ar_after_stall = 0;
        init_dma_sys_addr = a;
        buf_boundary = bb;
        block_count = bc;
        blk_count_ena = ena;
        @(negedge clock) start_xfer = 1'b1;
        @(negedge clock) start_xfer = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outs", {fifo_wr_en, addr_read_valid, read_data_ready, dma_done,
                           dma_error, dma_boundary_int}, 64'd0);
        chk("reset_addr_data", {read_addr, fifo_wr_data}, 64'd0);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);

        // Direction = 1 is not this engine
        dir_dat_trans_mode = 1'b1;
        launch(32'h1000_0000, 3'd0, 16'd2, 1'b1);
        repeat (4) @(negedge clock);
        chk("dir1_ignored", 64'(busy), 64'd0);
        dir_dat_trans_mode = 1'b0;

        // Two blocks, zero-wait
        launch(32'h1000_0000, 3'd0, 16'd2, 1'b1);
        wait_idle(5000, "t1_idle");
        chk("t1_words", 64'(wr_q.size()), 64'd256);
        check_seq(0, 256, 32'h1000_0000, "t1_data");
        chk("t1_done", 64'(done_cnt), 64'd1);
        chk("t1_bnd", 64'(bnd_cnt), 64'd0);

        // Boundary after 8 blocks, address reload, total 10 blocks
        launch(32'h1000_0000, 3'd0, 16'd10, 1'b1);
        n = 0;
        while (bnd_cnt == 0 && n < 10000) begin @(negedge clock); n++; end
        chk("t2_bnd_seen", 64'(bnd_cnt), 64'd1);
        repeat (20) @(negedge clock);
        chk("t2_stalled_words", 64'(wr_q.size()), 64'd1024);
        chk("t2_stalled_ar", {addr_read_valid, busy}, 64'b01);
        sys_addr_changed = 1'b1;
        init_dma_sys_addr = 32'h2000_0000;
        @(negedge clock) sys_addr_changed = 1'b0;
        wait_idle(3000, "t2_idle");
        chk("t2_words", 64'(wr_q.size()), 64'd1280);
        check_seq(0, 1024, 32'h1000_0000, "t2_data_a");
        check_seq(1024, 256, 32'h2000_0000, "t2_data_b");
        chk("t2_done", 64'(done_cnt), 64'd1);
        chk("t2_bnd_total", 64'(bnd_cnt), 64'd1);

        // FIFO-full stall of 50 cycles after word 5
        stall_after = 5;
        launch(32'h0400_0000, 3'd0, 16'd1, 1'b1);
        wait_idle(3000, "t3_idle");
        stall_after = -1;
        chk("t3_words", 64'(wr_q.size()), 64'd128);
        check_seq(0, 128, 32'h0400_0000, "t3_data");
        chk("t3_ar_during_full", 64'(ar_during_full), 64'd0);
        chk("t3_ar_after_stall", 64'(ar_after_stall), 64'd1);

        // Slow slave: ARREADY after 3 cycles, RVALID after 4
        ar_delay = 3; r_delay = 4;
        launch(32'h0800_0100, 3'd0, 16'd1, 1'b1);
        wait_idle(5000, "t4_idle");
        ar_delay = 0; r_delay = 0;
        chk("t4_words", 64'(wr_q.size()), 64'd128);
        check_seq(0, 128, 32'h0800_0100, "t4_data");
        chk("t4_addr_stable", 64'(addr_unstable), 64'd0);
        chk("t4_ar_handshakes", 64'(ar_hs), 64'd128);

        // Error response on word 40
        err_word = 40;
        launch(32'h0C00_0000, 3'd0, 16'd2, 1'b1);
        n = 0;
        while (err_cnt == 0 && n < 2000) begin @(negedge clock); n++; end
        err_word = -1;
        repeat (10) @(negedge clock);
        chk("t5_err_pulse", 64'(err_cnt), 64'd1);
        chk("t5_words", 64'(wr_q.size()), 64'd40);
        check_seq(0, 40, 32'h0C00_0000, "t5_data");
        chk("t5_held", {busy, addr_read_valid, read_data_ready}, 64'b100);
        dma_ena_trans_mode = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        dma_ena_trans_mode = 1'b1;

        // Asynchronous reset in the middle of block 1, then restart
        launch(32'h1000_0000, 3'd0, 16'd2, 1'b1);
        n = 0;
        while (!(wr_q.size() >= 130 && read_data_ready) && n < 3000) begin
            @(negedge clock); n++;
        end
        chk("t6_in_data", 64'(read_data_ready), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_outs", {busy, fifo_wr_en, addr_read_valid, read_data_ready,
                              dma_done, dma_error, dma_boundary_int}, 64'd0);
        chk("t6_async_addr", {read_addr, fifo_wr_data}, 64'd0);
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
        launch(32'h3000_0000, 3'd0, 16'd1, 1'b1);
        wait_idle(3000, "t6_idle");
        chk("t6_words", 64'(wr_q.size()), 64'd128);
        check_seq(0, 128, 32'h3000_0000, "t6_data");
        chk("t6_done", 64'(done_cnt), 64'd1);

        // block_count = 0 moves exactly one block
        launch(32'h0000_1000, 3'd0, 16'd0, 1'b1);
        wait_idle(3000, "t7_idle");
        chk("t7_words", 64'(wr_q.size()), 64'd128);
        chk("t7_done", 64'(done_cnt), 64'd1);

        // stop_xfer while parked at a buffer boundary
        launch(32'h1000_0000, 3'd0, 16'd10, 1'b1);
        n = 0;
        while (bnd_cnt == 0 && n < 10000) begin @(negedge clock); n++; end
        chk("t8_bnd_seen", 64'(bnd_cnt), 64'd1);
        stop_xfer = 1'b1;
        @(negedge clock);
        @(negedge clock);
        stop_xfer = 1'b0;
        chk("t8_idle", 64'(busy), 64'd0);
        chk("t8_no_done", 64'(done_cnt), 64'd0);
        chk("t8_words", 64'(wr_q.size()), 64'd1024);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
